// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Consumers: mem_arb_pick, mem_arbiter (optional macro MEM_ARB_RR_EN lives there).
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [1:0] WHB_BYTE = 2'b00;
    localparam logic [1:0] WHB_HALF = 2'b01;
    localparam logic [1:0] WHB_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store requests.
// MEM_ARB_RR_EN selects round-robin on the last owner; otherwise data beats fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_own,
`endif
    output logic win_valid,
    output logic win_own
);

    always_comb begin
        win_valid = if_req | d_req;
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
            win_own = (last_own == OWN_D) ? OWN_IF : OWN_D;
        end else begin
            win_own = d_req ? OWN_D : OWN_IF;
        end
`else
        win_own = d_req ? OWN_D : OWN_IF;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one outstanding transaction, IDLE->ISSUE->WAIT->RESP.
// Define MEM_ARB_RR_EN for round-robin priority; default is fixed data-over-fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_whb,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_whb,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          own_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    whb_q;
    logic [DW-1:0] resp_q;
    logic          win_valid;
    logic          win_own;
    logic          grant;

`ifdef MEM_ARB_RR_EN
    logic last_own;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_own <= OWN_D;
        end else if (grant) begin
            last_own <= win_own;
        end
    end
`endif

    mem_arb_pick u_pick (
        .if_req    (if_req),
        .d_req     (d_req),
`ifdef MEM_ARB_RR_EN
        .last_own  (last_own),
`endif
        .win_valid (win_valid),
        .win_own   (win_own)
    );

    // Gating with rst keeps the Mealy grants low while reset is held.
    assign grant  = rst && (state == ST_IDLE) && win_valid;
    assign if_gnt = grant && (win_own == OWN_IF);
    assign d_gnt  = grant && (win_own == OWN_D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            own_q   <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            whb_q   <= '0;
            resp_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        own_q <= win_own;
                        state <= ST_ISSUE;
                        if (win_own == OWN_D) begin
                            we_q    <= d_we;
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            whb_q   <= d_whb;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            whb_q   <= WHB_WORD;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt   <= 4'(MEM_LAT - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_q <= we_q ? '0 : mem_rdata;
                        state  <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign mem_en    = (state == ST_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign mem_whb   = mem_en ? whb_q   : '0;

    assign if_rvalid = (state == ST_RESP) && (own_q == OWN_IF);
    assign d_rvalid  = (state == ST_RESP) && (own_q == OWN_D);
    assign if_rdata  = if_rvalid ? resp_q : '0;
    assign d_rdata   = d_rvalid  ? resp_q : '0;

endmodule
